// File: rtl/corelet_seq_ctrl_pkg.sv
// corelet_seq_pkg: shared state encoding, instruction codes and counter sizing
// for the corelet layer sequencer.
package corelet_seq_pkg;
   typedef enum logic [2:0] {IDLE, LOAD_W, EXEC, DRAIN, READOUT, DONE} state_t;
   localparam logic [2:0] INST_IDLE  = 3'b000;
   localparam logic [2:0] INST_KLOAD = 3'b001;
   localparam logic [2:0] INST_EXEC  = 3'b010;
   // The counter only ever reaches (longest phase - 1), so clog2 of the longest phase suffices.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 2) ? 1 : $clog2(m);
   endfunction
endpackage

// File: rtl/corelet_seq_ctrl_if.sv
// corelet_seq_ctrl_if: host start handshake plus SRAM/corelet control bundle;
// master is the sequencer, slave is the host/corelet side.
interface corelet_seq_ctrl_if #(parameter int ADDR_W = 11);
   logic              start;
   logic              is_os;
   logic              stall;
   logic              busy;
   logic              done;
   logic              xmem_cen;
   logic [ADDR_W-1:0] xmem_addr;
   logic [2:0]        inst_w;
   logic [3:0]        kij;
   logic              readout_start;
   logic [31:0]       perf_cycles;
   modport master (input start, is_os, stall,
                   output busy, done, xmem_cen, xmem_addr, inst_w, kij, readout_start, perf_cycles);
   modport slave  (output start, is_os, stall,
                   input busy, done, xmem_cen, xmem_addr, inst_w, kij, readout_start, perf_cycles);
endinterface

// File: rtl/corelet_seq_ctrl.sv
// corelet_seq_ctrl: walks the kernel positions issuing weight/activation reads and
// delayed inst_w codes, drains, then fires readout. Busy-cycle counter under CORELET_SEQ_PERF_CNT_EN.
module corelet_seq_ctrl
   import corelet_seq_pkg::*;
#(
   parameter int ROW         = 8,
   parameter int N_ACT       = 36,
   parameter int N_KIJ       = 9,
   parameter int DRAIN_CYC   = 16,
   parameter int READOUT_CYC = 16,
   parameter int ADDR_W      = 11,
   parameter int W_BASE      = 36
) (
   input logic                clk,
   input logic                reset,
   corelet_seq_ctrl_if.master bus
);
   localparam int CW = cnt_width(ROW, N_ACT, DRAIN_CYC, READOUT_CYC);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, len_m1;
   logic [3:0]      kij_q, kij_d;
   logic [2:0]      inst_q, inst_d;
   logic            os_q, os_d, busy_q, busy_d, done_q, done_d, rs_q, rs_d;
   logic            issue_st, issue, last;

   always_comb begin
      issue_st = state_q == LOAD_W || state_q == EXEC;
      issue    = issue_st && !bus.stall;
      len_m1   = state_q == LOAD_W ? CW'(ROW - 1) :
                 state_q == EXEC   ? CW'(N_ACT - 1) :
                 state_q == DRAIN  ? CW'(DRAIN_CYC - 1) : CW'(READOUT_CYC - 1);
      last     = cnt_q == len_m1;
      state_d  = state_q;
      kij_d    = kij_q;
      os_d     = os_q;
      unique case (state_q)
         IDLE: if (bus.start) begin
            os_d    = bus.is_os;
            kij_d   = '0;
            state_d = bus.is_os ? EXEC : LOAD_W;
         end
         LOAD_W:  if (issue && last) state_d = EXEC;
         EXEC:    if (issue && last) state_d = DRAIN;
         DRAIN:   if (last) begin
            if (!os_q && kij_q < 4'(N_KIJ - 1)) begin
               kij_d   = kij_q + 4'd1;
               state_d = LOAD_W;
            end else state_d = READOUT;
         end
         READOUT: if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cnt_d  = state_d != state_q ? '0 :
               issue_st ? cnt_q + CW'(issue) :
               (state_q == DRAIN || state_q == READOUT) ? cnt_q + CW'(1) : '0;
      // The code trails its read by one cycle so it meets the SRAM Q data at the corelet.
      inst_d = issue ? (state_q == LOAD_W ? INST_KLOAD : INST_EXEC) : INST_IDLE;
      busy_d = state_d != IDLE;
      done_d = state_d == DONE;
      rs_d   = state_d == READOUT && state_q != READOUT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         kij_q   <= '0;
         inst_q  <= INST_IDLE;
         os_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kij_q   <= kij_d;
         inst_q  <= inst_d;
         os_q    <= os_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rs_q    <= rs_d;
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.xmem_cen      = !issue;
   assign bus.xmem_addr     = state_q == LOAD_W ? ADDR_W'(W_BASE) + ADDR_W'(kij_q) * ADDR_W'(ROW) + ADDR_W'(cnt_q) :
                              state_q == EXEC   ? ADDR_W'(cnt_q) : '0;
   assign bus.inst_w        = inst_q;
   assign bus.kij           = kij_q;
   assign bus.readout_start = rs_q;

`ifdef CORELET_SEQ_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;
   always_comb perf_d = (state_q == IDLE && bus.start) ? '0 :
                        (busy_q && perf_q != '1) ? perf_q + 32'd1 : perf_q;
   always_ff @(posedge clk) perf_q <= reset ? '0 : perf_d;
   assign bus.perf_cycles = perf_q;
`else
   assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_corelet_seq_ctrl.sv
// tb_corelet_seq_ctrl: randomized stimulus checked cycle by cycle against a
// schedule model built from the layer's phase list (issue slots, drain, readout, done).
module tb_corelet_seq_ctrl;
   import corelet_seq_pkg::*;
   localparam int ROW = 8, N_ACT = 36, N_KIJ = 9, DRAIN = 16, READOUT = 16, W_BASE = 36;
   localparam int LIMIT = 5000;
`ifdef CORELET_SEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   corelet_seq_ctrl_if #(.ADDR_W(11)) bus();
   corelet_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // kind: 1 weight issue, 2 activation issue, 3 drain, 4 first readout, 5 readout, 6 done
   typedef struct {int kind; int addr; int kij;} slot_t;
   slot_t sched[$];

   function automatic void build(input bit os);
      int nk;
      nk = os ? 1 : N_KIJ;
      sched.delete();
      for (int k = 0; k < nk; k++) begin
         if (!os) for (int c = 0; c < ROW; c++) sched.push_back('{1, W_BASE + k * ROW + c, k});
         for (int c = 0; c < N_ACT; c++) sched.push_back('{2, c, k});
         for (int c = 0; c < DRAIN; c++) sched.push_back('{3, 0, k});
      end
      sched.push_back('{4, 0, nk - 1});
      for (int c = 1; c < READOUT; c++) sched.push_back('{5, 0, nk - 1});
      sched.push_back('{6, 0, nk - 1});
   endfunction

   function automatic logic [53:0] observed();
      return {bus.busy, bus.done, bus.xmem_cen, bus.xmem_addr, bus.inst_w, bus.kij, bus.readout_start, bus.perf_cycles};
   endfunction

   task automatic check_reset_vals(input string name);
      logic [53:0] exp_v;
      exp_v = {1'b0, 1'b0, 1'b1, 11'd0, 3'd0, 4'd0, 1'b0, 32'd0};
      n_cmp++;
      if (observed() !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, observed(), exp_v);
      end
   endtask

   task automatic run_layer(input bit os, input int stall_pct, input int noise_pct,
                            input bit dstall, input int abort_at, input string name);
      int idx, cyc, stalled, dcnt, n_busy, n_k, n_e, n_rs, n_done, nk;
      logic [2:0] prev;
      logic [53:0] exp_v;
      logic [4:0] idle_got;
      bit iss, st;
      slot_t s;
      build(os);
      nk = os ? 1 : N_KIJ;
      {idx, cyc, stalled, dcnt, n_busy, n_k, n_e, n_rs, n_done} = '0;
      prev = INST_IDLE;
      @(negedge clk);
      bus.start = 1'b1;
      bus.is_os = os;
      bus.stall = 1'b0;
      @(negedge clk);
      bus.is_os = 1'($urandom);
      while (idx < sched.size() && cyc < LIMIT) begin
         s = sched[idx];
         iss = s.kind <= 2;
         st = $urandom_range(99) < stall_pct;
         if (dstall && s.kind == 2 && s.kij == 0 && s.addr == 10 && dcnt < 3) begin
            st = 1'b1;
            dcnt++;
         end
         bus.stall = st;
         bus.start = ($urandom_range(99) < noise_pct) || (noise_pct > 0 && s.kind == 6);
         #1;
         exp_v = {1'b1, s.kind == 6, !(iss && !st), iss ? 11'(s.addr) : 11'd0, prev,
                  4'(s.kij), s.kind == 4, PERF ? 32'(cyc) : 32'd0};
         n_cmp++;
         if (observed() !== exp_v) begin
            n_bad++;
            $display("FAIL %s cycle %0d slot %0d: got %h expected %h", name, cyc, idx, observed(), exp_v);
         end
         n_busy += int'(bus.busy);
         n_k    += int'(bus.inst_w == INST_KLOAD);
         n_e    += int'(bus.inst_w == INST_EXEC);
         n_rs   += int'(bus.readout_start);
         n_done += int'(bus.done);
         if (iss && st) begin
            stalled++;
            prev = INST_IDLE;
         end else begin
            prev = iss ? 3'(s.kind) : INST_IDLE;
            idx++;
         end
         cyc++;
         if (cyc == abort_at) begin
            bus.start = 1'b0;
            bus.stall = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check_reset_vals({name, " after abort"});
            n_cmp++;
            if (n_done !== 0) begin
               n_bad++;
               $display("FAIL %s done pulses before abort: got %0d expected 0", name, n_done);
            end
            return;
         end
         @(negedge clk);
      end
      if (cyc >= LIMIT) begin
         n_bad++;
         $display("FAIL %s timeout: got %0d cycles expected %0d", name, cyc, sched.size());
      end
      bus.start = 1'b0;
      bus.stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         idle_got = {bus.busy, bus.done, bus.xmem_cen, bus.readout_start, bus.inst_w != 3'd0};
         n_cmp++;
         if (idle_got !== 5'b00100 || bus.perf_cycles !== (PERF ? 32'(cyc) : 32'd0)) begin
            n_bad++;
            $display("FAIL %s idle %0d: got %b perf %0d expected 00100 perf %0d",
                     name, i, idle_got, bus.perf_cycles, PERF ? cyc : 0);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (n_busy !== (os ? N_ACT + DRAIN + READOUT + 1 : N_KIJ * (ROW + N_ACT + DRAIN) + READOUT + 1) + stalled) begin
         n_bad++;
         $display("FAIL %s busy count: got %0d expected %0d", name, n_busy,
                  (os ? N_ACT + DRAIN + READOUT + 1 : N_KIJ * (ROW + N_ACT + DRAIN) + READOUT + 1) + stalled);
      end
      n_cmp++;
      if (n_k !== (os ? 0 : N_KIJ * ROW) || n_e !== nk * N_ACT) begin
         n_bad++;
         $display("FAIL %s code counts: got kload %0d exec %0d expected %0d %0d",
                  name, n_k, n_e, os ? 0 : N_KIJ * ROW, nk * N_ACT);
      end
      n_cmp++;
      if (n_rs !== 1 || n_done !== 1) begin
         n_bad++;
         $display("FAIL %s pulses: got readout %0d done %0d expected 1 1", name, n_rs, n_done);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.is_os = 1'b0;
      bus.stall = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      #1;
      check_reset_vals("reset held");
      bus.start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      #1;
      check_reset_vals("idle after reset");
   endtask

   task automatic test_ws_full();
      run_layer(1'b0, 0, 0, 1'b0, -1, "ws_full");
   endtask

   task automatic test_os();
      run_layer(1'b1, 0, 0, 1'b0, -1, "os");
   endtask

   task automatic test_stall();
      run_layer(1'b0, 0, 0, 1'b1, -1, "stall_directed");
      run_layer(1'b0, 20, 0, 1'b0, -1, "stall_random_ws");
      run_layer(1'b1, 30, 0, 1'b0, -1, "stall_random_os");
   endtask

   task automatic test_reset_abort();
      run_layer(1'b0, 0, 0, 1'b0, 4 * (ROW + N_ACT + DRAIN) + ROW + $urandom_range(1, N_ACT - 1), "abort");
      run_layer(1'b0, 10, 0, 1'b0, -1, "restart");
   endtask

   task automatic test_start_ignored();
      run_layer(1'b0, 10, 30, 1'b0, -1, "start_ignored_ws");
      run_layer(1'b1, 0, 50, 1'b0, -1, "start_ignored_os");
   endtask

   initial begin
      test_reset();
      test_ws_full();
      test_os();
      test_stall();
      test_reset_abort();
      test_start_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
